// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus-attached UART transmitter: register offsets,
// STATUS bit positions, FSM encodings and the baud divider reset default.
package bus_uart_tx_pkg;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd103;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVIDER = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

    // Count is passed zero-extended so the layout does not depend on FIFO depth.
    function automatic logic [31:0] packStatus(input logic [27:0] countExt,
                                               input logic overrun,
                                               input logic empty,
                                               input logic full,
                                               input logic busy);
        logic [31:0] word;
        word                = '0;
        word[31:4]          = countExt;
        word[STAT_OVERRUN]  = overrun;
        word[STAT_EMPTY]    = empty;
        word[STAT_FULL]     = full;
        word[STAT_BUSY]     = busy;
        return word;
    endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// CPU-side register bus of the UART transmitter; the SoC drives it as master.
interface bus_uart_tx_if;

    logic        cs;
    logic [1:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, output addr, output wstrb, output wdata, input rdata);
    modport slave  (input cs, input addr, input wstrb, input wdata, output rdata);

endinterface

// File: rtl/bus_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes into a full FIFO are ignored
// even when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud counter
// and the serialising FSM with a registered txd output.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter int          FIFO_AW   = 4,
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    bus_uart_tx_if.slave      bus,
    output logic              txd,
    output logic              irq
);

    txState_t          r_state;
    txState_t          w_nextState;
    logic [7:0]        r_shift;
    logic [7:0]        w_shiftNext;
    logic [2:0]        r_bitIdx;
    logic [2:0]        w_bitIdxNext;
    logic [15:0]       r_baudCnt;
    logic [15:0]       w_baudNext;
    logic              r_txd;
    logic              w_txdNext;
    logic              w_pop;
    logic              w_bitDone;
    logic              w_busy;

    logic [15:0]       r_divider;
    logic              r_irqEn;
    logic              r_overrun;
    logic [31:0]       r_rdata;

    logic              w_write;
    logic              w_read;
    logic              w_dataWr;
    logic              w_overrunEvt;
    logic              w_statusRd;
    logic [7:0]        w_fifoHead;
    logic [FIFO_AW:0]  w_fifoCount;
    logic              w_fifoEmpty;
    logic              w_fifoFull;
    logic              w_unusedWdata;

    assign w_write       = bus.cs & (|bus.wstrb);
    assign w_read        = bus.cs & (bus.wstrb == 4'b0000);
    assign w_dataWr      = w_write & (bus.addr == REG_DATA) & bus.wstrb[0];
    assign w_overrunEvt  = w_dataWr & w_fifoFull;
    assign w_statusRd    = w_read & (bus.addr == REG_STATUS);
    assign w_unusedWdata = ^bus.wdata[31:16];

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_dataWr),
        .i_data  (bus.wdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifoHead),
        .o_count (w_fifoCount),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_divider <= DIV_RESET;
            r_irqEn   <= 1'b0;
        end else if (w_write) begin
            if (bus.addr == REG_DIVIDER) begin
                if (bus.wstrb[0]) r_divider[7:0]  <= bus.wdata[7:0];
                if (bus.wstrb[1]) r_divider[15:8] <= bus.wdata[15:8];
            end
            if ((bus.addr == REG_CTRL) && bus.wstrb[0]) begin
                r_irqEn <= bus.wdata[0];
            end
        end
    end

    // A fresh overrun on the same edge as a STATUS read wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_overrunEvt | (r_overrun & ~w_statusRd);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_read) begin
            case (bus.addr)
                REG_STATUS:  r_rdata <= packStatus(28'(w_fifoCount), r_overrun,
                                                   w_fifoEmpty, w_fifoFull, w_busy);
                REG_DIVIDER: r_rdata <= {16'h0000, r_divider};
                REG_CTRL:    r_rdata <= {31'b0, r_irqEn};
                default:     r_rdata <= '0;
            endcase
        end
    end

    assign bus.rdata = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_bitDone = (r_baudCnt == 16'd0);

    // txd is computed one step ahead so the output flop already holds the
    // level of the state being entered.
    always_comb begin
        w_nextState  = r_state;
        w_shiftNext  = r_shift;
        w_bitIdxNext = r_bitIdx;
        w_baudNext   = r_baudCnt;
        w_txdNext    = r_txd;
        w_pop        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_txdNext = 1'b1;
                if (!w_fifoEmpty) begin
                    w_pop        = 1'b1;
                    w_shiftNext  = w_fifoHead;
                    w_baudNext   = r_divider;
                    w_bitIdxNext = 3'd0;
                    w_txdNext    = 1'b0;
                    w_nextState  = TX_START;
                end
            end
            TX_START: begin
                if (w_bitDone) begin
                    w_baudNext  = r_divider;
                    w_txdNext   = r_shift[0];
                    w_nextState = TX_DATA;
                end else begin
                    w_baudNext = r_baudCnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (w_bitDone) begin
                    w_baudNext = r_divider;
                    if (r_bitIdx == 3'd7) begin
                        w_txdNext   = 1'b1;
                        w_nextState = TX_STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                        w_shiftNext  = {1'b0, r_shift[7:1]};
                        w_txdNext    = r_shift[1];
                    end
                end else begin
                    w_baudNext = r_baudCnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (w_bitDone) begin
                    w_txdNext   = 1'b1;
                    w_nextState = TX_IDLE;
                end else begin
                    w_baudNext = r_baudCnt - 16'd1;
                end
            end
            default: begin
                w_txdNext   = 1'b1;
                w_nextState = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bitIdx  <= '0;
            r_baudCnt <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_shift   <= w_shiftNext;
            r_bitIdx  <= w_bitIdxNext;
            r_baudCnt <= w_baudNext;
            r_txd     <= w_txdNext;
        end
    end

    assign w_busy = (r_state != TX_IDLE);
    assign txd    = r_txd;
    assign irq    = r_irqEn & w_fifoEmpty & ~w_busy;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed self-checking bench for bus_uart_tx: register access, frame timing,
// FIFO fill/overrun, interrupt, mid-frame divider change and async reset.
module tb_bus_uart_tx;
    import bus_uart_tx_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic txd;
    logic irq;
    int   checkCount = 0;
    int   failCount  = 0;

    always #5 clk = ~clk;

    bus_uart_tx_if busIf ();

    bus_uart_tx #(
        .FIFO_AW   (4),
        .DIV_RESET (16'd103)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf),
        .txd   (txd),
        .irq   (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        busIf.cs    = 1'b1;
        busIf.addr  = a;
        busIf.wdata = d;
        busIf.wstrb = s;
        @(negedge clk);
        busIf.cs    = 1'b0;
        busIf.wstrb = 4'b0000;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        busIf.cs    = 1'b1;
        busIf.addr  = a;
        busIf.wstrb = 4'b0000;
        @(negedge clk);
        busIf.cs    = 1'b0;
        d           = busIf.rdata;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame55;
        logic [0:21] exp35;
        int          busyCycles;
        int          seg;
        int          left;
        int          dur [10];
        logic        expT;

        frame55 = {1'b1, 8'h55, 1'b0};
        exp35   = 22'b01000010111_00011110011;
        dur     = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8};

        busIf.cs    = 1'b0;
        busIf.addr  = 2'd0;
        busIf.wstrb = 4'b0000;
        busIf.wdata = '0;
        reset       = 1'b0;
        #1 reset    = 1'b1;
        #1;
        checkOutput("reset_txd", 32'(txd), 32'd1);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_rdata", busIf.rdata, 32'd0);
        #20 reset = 1'b0;
        @(negedge clk);

        readReg(REG_STATUS, rd);  checkOutput("reset_status", rd, 32'h004);
        readReg(REG_DIVIDER, rd); checkOutput("reset_divider", rd, 32'd103);
        readReg(REG_DATA, rd);    checkOutput("data_reads_zero", rd, 32'd0);
        readReg(REG_CTRL, rd);    checkOutput("reset_ctrl", rd, 32'd0);

        // 0x55 at divider 3 while STATUS is read continuously to track busy.
        applyStimulus(REG_DIVIDER, 32'd3, 4'b0011);
        applyStimulus(REG_DATA, 32'h55, 4'b0001);
        busIf.cs    = 1'b1;
        busIf.addr  = REG_STATUS;
        busIf.wstrb = 4'b0000;
        busyCycles  = 0;
        for (int k = 0; k <= 44; k++) begin
            expT = (k >= 1 && k <= 40) ? frame55[(k-1)/4] : 1'b1;
            checkOutput($sformatf("f55_txd_%0d", k), 32'(txd), 32'(expT));
            @(negedge clk);
            if (busIf.rdata[STAT_BUSY]) busyCycles++;
        end
        busIf.cs = 1'b0;
        checkOutput("f55_busy_cycles", 32'(busyCycles), 32'd40);

        // Back-to-back 0xA1, 0x3C at divider 0.
        applyStimulus(REG_DIVIDER, 32'd0, 4'b0011);
        applyStimulus(REG_DATA, 32'hA1, 4'b0001);
        applyStimulus(REG_DATA, 32'h3C, 4'b0001);
        for (int k = 1; k <= 22; k++) begin
            checkOutput($sformatf("b2b_txd_%0d", k), 32'(txd), 32'(exp35[k-1]));
            @(negedge clk);
        end

        // Interrupt follows full drain of the transmitter.
        applyStimulus(REG_CTRL, 32'd1, 4'b0001);
        checkOutput("irq_idle_enabled", 32'(irq), 32'd1);
        applyStimulus(REG_DATA, 32'h5A, 4'b0001);
        for (int k = 0; k <= 11; k++) begin
            checkOutput($sformatf("irq_%0d", k), 32'(irq), (k >= 11) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        applyStimulus(REG_CTRL, 32'd0, 4'b0001);
        checkOutput("irq_disabled", 32'(irq), 32'd0);

        // Divider 3 -> 7 written during data bit 2.
        applyStimulus(REG_DIVIDER, 32'd3, 4'b0011);
        applyStimulus(REG_DATA, 32'h55, 4'b0001);
        checkOutput("divchg_txd_0", 32'(txd), 32'd1);
        @(negedge clk);
        seg  = 0;
        left = dur[0];
        for (int k = 1; k <= 66; k++) begin
            expT = (seg < 10) ? frame55[seg] : 1'b1;
            checkOutput($sformatf("divchg_txd_%0d", k), 32'(txd), 32'(expT));
            if (k == 14) begin
                busIf.cs    = 1'b1;
                busIf.addr  = REG_DIVIDER;
                busIf.wdata = 32'd7;
                busIf.wstrb = 4'b0001;
            end else if (k == 15) begin
                busIf.cs    = 1'b0;
                busIf.wstrb = 4'b0000;
            end
            if (seg < 10) begin
                left--;
                if (left == 0) begin
                    seg++;
                    if (seg < 10) left = dur[seg];
                end
            end
            @(negedge clk);
        end

        // Fill the FIFO behind a very slow frame, then overflow it.
        applyStimulus(REG_DIVIDER, 32'd1000, 4'b0011);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(REG_DATA, 32'(i), 4'b0001);
        end
        readReg(REG_STATUS, rd); checkOutput("fifo_full_status", rd, 32'h103);
        applyStimulus(REG_DATA, 32'hEE, 4'b0001);
        readReg(REG_STATUS, rd); checkOutput("overrun_set", rd, 32'h10B);
        readReg(REG_STATUS, rd); checkOutput("overrun_cleared", rd, 32'h103);

        applyStimulus(REG_DIVIDER, 32'hAABBCC05, 4'b0001);
        readReg(REG_DIVIDER, rd); checkOutput("div_strobe_lo", rd, 32'h0305);
        applyStimulus(REG_DIVIDER, 32'h00001200, 4'b0010);
        readReg(REG_DIVIDER, rd); checkOutput("div_strobe_hi", rd, 32'h1205);
        applyStimulus(REG_CTRL, 32'd1, 4'b0010);
        readReg(REG_CTRL, rd); checkOutput("ctrl_strobe_off", rd, 32'd0);

        reset = 1'b1;
        #12 reset = 1'b0;
        @(negedge clk);
        readReg(REG_STATUS, rd); checkOutput("reset_drops_queue", rd, 32'h004);

        // Reset asserted during data bit 4 of 0x00.
        applyStimulus(REG_DIVIDER, 32'd3, 4'b0011);
        applyStimulus(REG_DATA, 32'h00, 4'b0001);
        repeat (22) @(negedge clk);
        checkOutput("midframe_bit4_low", 32'(txd), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_txd", 32'(txd), 32'd1);
        checkOutput("async_reset_rdata", busIf.rdata, 32'd0);
        #10 reset = 1'b0;
        @(negedge clk);
        readReg(REG_STATUS, rd);  checkOutput("post_reset_status", rd, 32'h004);
        readReg(REG_DIVIDER, rd); checkOutput("post_reset_divider", rd, 32'd103);
        checkOutput("post_reset_txd", 32'(txd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
